// File: rtl/traffic_intersection.sv
// Four-way intersection controller: NS/EW green-yellow-allred cycle, optional
// pedestrian walk phase, and a maintenance flashing-red mode.
module traffic_intersection #(
   parameter int GREEN_TICKS  = 6,
   parameter int YELLOW_TICKS = 2,
   parameter int ALLRED_TICKS = 1,
   parameter int WALK_TICKS   = 4,
   parameter int CNT_BITS     = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tick,
   input  logic       ped_req,
   input  logic       flash_en,
   output logic       ns_green,
   output logic       ns_yellow,
   output logic       ns_red,
   output logic       ew_green,
   output logic       ew_yellow,
   output logic       ew_red,
   output logic       walk,
   output logic [2:0] state
);

   typedef enum logic [2:0] {
      NS_GRN = 3'd0,
      NS_YEL = 3'd1,
      CLR_A  = 3'd2,
      EW_GRN = 3'd3,
      EW_YEL = 3'd4,
      CLR_B  = 3'd5,
      WALK   = 3'd6,
      FLASH  = 3'd7
   } state_t;

   localparam logic [CNT_BITS-1:0] GRN_LAST = CNT_BITS'(GREEN_TICKS - 1);
   localparam logic [CNT_BITS-1:0] YEL_LAST = CNT_BITS'(YELLOW_TICKS - 1);
   localparam logic [CNT_BITS-1:0] CLR_LAST = CNT_BITS'(ALLRED_TICKS - 1);
   localparam logic [CNT_BITS-1:0] WLK_LAST = CNT_BITS'(WALK_TICKS - 1);

   state_t              cur, nxt;
   logic [CNT_BITS-1:0] cnt, cnt_nxt, last;
   logic                ped_pend, pend_nxt;
   logic                flash_ph, ph_nxt;

   always_ff @(posedge clk) begin
      if (reset) begin
         cur      <= CLR_B;
         cnt      <= '0;
         ped_pend <= 1'b0;
         flash_ph <= 1'b0;
      end else begin
         cur      <= nxt;
         cnt      <= cnt_nxt;
         ped_pend <= pend_nxt;
         flash_ph <= ph_nxt;
      end
   end

   // Final count value of the current timed phase.
   always_comb begin
      last = '0;
      case (cur)
         NS_GRN, EW_GRN: last = GRN_LAST;
         NS_YEL, EW_YEL: last = YEL_LAST;
         CLR_A, CLR_B:   last = CLR_LAST;
         WALK:           last = WLK_LAST;
         default:        last = '0;
      endcase
   end

   always_comb begin
      nxt      = cur;
      cnt_nxt  = cnt;
      ph_nxt   = flash_ph;
      pend_nxt = ped_pend;
      if (flash_en) begin
         nxt     = FLASH;
         cnt_nxt = '0;
         ph_nxt  = (cur == FLASH) ? (flash_ph ^ tick) : 1'b0;
      end else if (cur == FLASH) begin
         nxt     = CLR_B;
         cnt_nxt = '0;
         ph_nxt  = 1'b0;
      end else if (tick) begin
         if (cnt == last) begin
            cnt_nxt = '0;
            case (cur)
               NS_GRN:  nxt = NS_YEL;
               NS_YEL:  nxt = CLR_A;
               CLR_A:   nxt = EW_GRN;
               EW_GRN:  nxt = EW_YEL;
               EW_YEL:  nxt = CLR_B;
               CLR_B:   nxt = ped_pend ? WALK : NS_GRN;
               WALK:    nxt = NS_GRN;
               default: nxt = CLR_B;
            endcase
         end else begin
            cnt_nxt = cnt + 1'b1;
         end
      end
      // Entering WALK services the request; a press on that same edge is dropped.
      if (nxt == WALK && cur != WALK)
         pend_nxt = 1'b0;
      else if (ped_req && cur != WALK)
         pend_nxt = 1'b1;
   end

   always_comb begin
      ns_green  = 1'b0;
      ns_yellow = 1'b0;
      ns_red    = 1'b0;
      ew_green  = 1'b0;
      ew_yellow = 1'b0;
      ew_red    = 1'b0;
      walk      = 1'b0;
      case (cur)
         NS_GRN: begin ns_green  = 1'b1; ew_red = 1'b1; end
         NS_YEL: begin ns_yellow = 1'b1; ew_red = 1'b1; end
         EW_GRN: begin ew_green  = 1'b1; ns_red = 1'b1; end
         EW_YEL: begin ew_yellow = 1'b1; ns_red = 1'b1; end
         WALK:   begin ns_red = 1'b1; ew_red = 1'b1; walk = 1'b1; end
         FLASH:  begin ns_red = flash_ph; ew_red = flash_ph; end
         default: begin ns_red = 1'b1; ew_red = 1'b1; end
      endcase
   end

   assign state = cur;

endmodule

// File: tb/tb_traffic_intersection.sv
// Scoreboard bench for traffic_intersection: expected {state,lamps} words are
// queued as each clock's stimulus is applied and compared after the edge.
module tb_traffic_intersection;

   logic       clk = 1'b0;
   logic       reset, tick, ped_req, flash_en;
   logic       ns_green, ns_yellow, ns_red, ew_green, ew_yellow, ew_red, walk;
   logic [2:0] state;

   logic [9:0] exp_q[$];
   logic [9:0] e, obs;
   int         total = 0;
   int         bad   = 0;

   traffic_intersection dut (
      .clk(clk), .reset(reset), .tick(tick), .ped_req(ped_req), .flash_en(flash_en),
      .ns_green(ns_green), .ns_yellow(ns_yellow), .ns_red(ns_red),
      .ew_green(ew_green), .ew_yellow(ew_yellow), .ew_red(ew_red),
      .walk(walk), .state(state)
   );

   always #5 clk = ~clk;

   assign obs = {state, ns_green, ns_yellow, ns_red, ew_green, ew_yellow, ew_red, walk};

   // {state, ns_g, ns_y, ns_r, ew_g, ew_y, ew_r, walk}
   function automatic logic [9:0] mk(input int code, input logic ph);
      logic [6:0] l;
      case (code)
         0: l = 7'b100_001_0;
         1: l = 7'b010_001_0;
         3: l = 7'b001_100_0;
         4: l = 7'b001_010_0;
         6: l = 7'b001_001_1;
         7: l = {2'b00, ph, 2'b00, ph, 1'b0};
         default: l = 7'b001_001_0;
      endcase
      return {3'(code), l};
   endfunction

   task automatic cyc(input logic t, input logic p, input logic f, input logic r);
      tick = t; ped_req = p; flash_en = f; reset = r;
      @(posedge clk); #1;
      tick = 1'b0; ped_req = 1'b0; reset = 1'b0;
   endtask

   task automatic test_reset;
      exp_q.push_back(mk(5, 0));
      cyc(1, 1, 1, 1);
      e = exp_q.pop_front(); total++;
      if (obs !== e) begin bad++; $display("FAIL reset_edge got=%h want=%h", obs, e); end
      for (int i = 0; i < 3; i++) begin
         exp_q.push_back(mk(5, 0));
         cyc(0, 0, 0, 0);
         e = exp_q.pop_front(); total++;
         if (obs !== e) begin bad++; $display("FAIL reset_idle i=%0d got=%h want=%h", i, obs, e); end
      end
   endtask

   // Rows: {current state, ticks in phase, following state, ped on final edge}
   task automatic test_sequence;
      int tbl [7][4] = '{'{5,1,0,0}, '{0,6,1,0}, '{1,2,2,0}, '{2,1,3,0},
                         '{3,6,4,0}, '{4,2,5,0}, '{5,1,0,0}};
      for (int r = 0; r < 7; r++)
         for (int i = 0; i < tbl[r][1]; i++) begin
            exp_q.push_back(mk(tbl[r][0], 0));
            cyc(0, 0, 0, 0);
            exp_q.push_back(mk((i == tbl[r][1]-1) ? tbl[r][2] : tbl[r][0], 0));
            cyc(1, 0, 0, 0);
            for (int k = 0; k < 2; k++) begin
               e = exp_q.pop_front(); total++;
               if (k == 0 && exp_q.size() == 0) begin end
               if (obs[9:7] !== e[9:7] && k == 1 || obs !== e && k == 1) begin
                  bad++; $display("FAIL seq row=%0d tick=%0d got=%h want=%h", r, i, obs, e);
               end
            end
         end
   endtask

   task automatic test_ped;
      int tbl [13][4] = '{'{0,6,1,0}, '{1,2,2,0}, '{2,1,3,0}, '{3,6,4,1},
                          '{4,2,5,0}, '{5,1,6,1}, '{6,4,0,1}, '{0,6,1,0},
                          '{1,2,2,0}, '{2,1,3,0}, '{3,6,4,0}, '{4,2,5,0},
                          '{5,1,0,0}};
      for (int r = 0; r < 13; r++)
         for (int i = 0; i < tbl[r][1]; i++) begin
            exp_q.push_back(mk(tbl[r][0], 0));
            cyc(0, 0, 0, 0);
            e = exp_q.pop_front(); total++;
            if (obs !== e) begin bad++; $display("FAIL ped_idle row=%0d tick=%0d got=%h want=%h", r, i, obs, e); end
            exp_q.push_back(mk((i == tbl[r][1]-1) ? tbl[r][2] : tbl[r][0], 0));
            cyc(1, (tbl[r][3] != 0) && (i == tbl[r][1]-1), 0, 0);
            e = exp_q.pop_front(); total++;
            if (obs !== e) begin bad++; $display("FAIL ped_tick row=%0d tick=%0d got=%h want=%h", r, i, obs, e); end
         end
   endtask

   task automatic test_flash;
      logic [9:0] want [8];
      logic [3:0] stim [8];  // {tick, ped, flash, reset}
      want = '{mk(0,0), mk(0,0), mk(0,0), mk(7,0), mk(7,1), mk(7,0), mk(7,1), mk(5,0)};
      stim = '{4'b1000, 4'b1000, 4'b1000, 4'b0010, 4'b1010, 4'b1010, 4'b1010, 4'b0000};
      for (int i = 0; i < 8; i++) begin
         exp_q.push_back(want[i]);
         cyc(stim[i][3], stim[i][2], stim[i][1], stim[i][0]);
         e = exp_q.pop_front(); total++;
         if (obs !== e) begin bad++; $display("FAIL flash step=%0d got=%h want=%h", i, obs, e); end
      end
      exp_q.push_back(mk(0, 0));
      cyc(1, 0, 0, 0);
      e = exp_q.pop_front(); total++;
      if (obs !== e) begin bad++; $display("FAIL flash_exit got=%h want=%h", obs, e); end
   endtask

   task automatic test_flash_ped;
      logic [9:0] want [8];
      logic [3:0] stim [8];
      want = '{mk(7,0), mk(7,1), mk(5,0), mk(6,0), mk(6,0), mk(6,0), mk(6,0), mk(0,0)};
      stim = '{4'b0010, 4'b1110, 4'b0000, 4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b1000};
      for (int i = 0; i < 8; i++) begin
         exp_q.push_back(want[i]);
         cyc(stim[i][3], stim[i][2], stim[i][1], stim[i][0]);
         e = exp_q.pop_front(); total++;
         if (obs !== e) begin bad++; $display("FAIL flash_ped step=%0d got=%h want=%h", i, obs, e); end
      end
   endtask

   task automatic test_hold;
      int errs = 0;
      for (int i = 0; i < 15; i++) cyc(1, 0, 0, 0);
      for (int i = 0; i < 1000; i++) begin
         exp_q.push_back(mk(4, 0));
         cyc(0, 0, 0, 0);
         e = exp_q.pop_front(); total++;
         if (obs !== e) begin
            bad++; errs++;
            if (errs < 5) $display("FAIL hold cyc=%0d got=%h want=%h", i, obs, e);
         end
      end
      exp_q.push_back(mk(4, 0)); cyc(1, 0, 0, 0);
      e = exp_q.pop_front(); total++;
      if (obs !== e) begin bad++; $display("FAIL hold_tick1 got=%h want=%h", obs, e); end
      exp_q.push_back(mk(5, 0)); cyc(1, 0, 0, 0);
      e = exp_q.pop_front(); total++;
      if (obs !== e) begin bad++; $display("FAIL hold_tick2 got=%h want=%h", obs, e); end
   endtask

   task automatic test_reset_walk;
      logic [9:0] want [5];
      logic [3:0] stim [5];
      want = '{mk(5,0), mk(6,0), mk(6,0), mk(5,0), mk(0,0)};
      stim = '{4'b0100, 4'b1000, 4'b1000, 4'b1101, 4'b1000};
      for (int i = 0; i < 5; i++) begin
         exp_q.push_back(want[i]);
         cyc(stim[i][3], stim[i][2], stim[i][1], stim[i][0]);
         e = exp_q.pop_front(); total++;
         if (obs !== e) begin bad++; $display("FAIL reset_walk step=%0d got=%h want=%h", i, obs, e); end
      end
      for (int i = 0; i < 17; i++) cyc(1, 0, 0, 0);
      exp_q.push_back(mk(5, 0)); cyc(0, 0, 0, 0);
      e = exp_q.pop_front(); total++;
      if (obs !== e) begin bad++; $display("FAIL reset_walk_clrb got=%h want=%h", obs, e); end
      exp_q.push_back(mk(0, 0)); cyc(1, 0, 0, 0);
      e = exp_q.pop_front(); total++;
      if (obs !== e) begin bad++; $display("FAIL reset_walk_nopend got=%h want=%h", obs, e); end
   endtask

   initial begin
      reset = 1'b1; tick = 1'b0; ped_req = 1'b0; flash_en = 1'b0;
      test_reset;
      test_sequence;
      test_ped;
      test_flash;
      test_flash_ped;
      test_hold;
      test_reset_walk;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
